er2_jtag_mailbox: RTL and testbench
===================================

# er2_jtag_mailbox

- One ER2 data register slot for the ER1/ER2 JTAG structure.
- Consumes JTDI/JSHIFT/JUPDATE and one IP_ENABLE bit from the ER1 decoder; drives one ER2_TDO bit back to it.
- Implements a byte mailbox between the JTAG host and an IP core: host writes are pushed into an RX FIFO, IP bytes are offered through a TX holding handshake.
- Everything runs in the JTCK domain; the IP side resynchronises if required.

## Interface
Parameters:
- RX_DEPTH, 4, RX FIFO depth in bytes; power of 2, at least 2.

Ports (clock and reset first):
- JTCK  in  1  JTAG clock; the only clock.
- JRSTN  in  1  asynchronous, active-low reset.
- JTDI  in  1  serial data in.
- JSHIFT  in  1  high in Shift-DR.
- JUPDATE  in  1  one-cycle pulse in Update-DR.
- JCE2  in  1  ER2 instruction active (Capture-DR/Shift-DR).
- IP_ENABLE  in  1  this slot's bit from the ER1 decoder.
- ER2_TDO  out  1  serial data out, equal to sr[0].
- rx_data  out  8  head byte of the RX FIFO; 0 when empty.
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  IP accepts rx_data.
- tx_data  in  8  byte offered to the host.
- tx_valid  in  1  tx_data valid; held until tx_ready.
- tx_ready  out  1  one-cycle pulse: host consumed tx_data.

## Operation
- sel = JCE2 & IP_ENABLE.
- Shift register sr is 11 bits wide (12 bits with the parity option).
- Capture, when sel & !JSHIFT:
  - sr[7:0] = tx_valid ? tx_data : 0
  - sr[8] = tx_valid
  - sr[9] = RX FIFO full
  - sr[10] = err sticky
- Shift, when sel & JSHIFT: sr = {JTDI, sr[N-1:1]}, LSB first out on ER2_TDO.
- Update, when JUPDATE & IP_ENABLE: decode op = sr[10:9], data = sr[7:0]; sr[8] is ignored.
  - 00: no operation.
  - 01: push data into the RX FIFO. If full and no pop in the same cycle, drop the byte and set err.
  - 10: if tx_valid, pulse tx_ready for one cycle; otherwise no effect.
  - 11: flush the RX FIFO (count to 0, pointers to 0) and clear err.
- RX pop: rx_valid & rx_ready.
- Simultaneous push and pop:
  - When full, the push is accepted and count is unchanged.
  - When empty, only the push takes effect.
- RX FIFO: wrap-around pointers of width log2(RX_DEPTH), plus a count of width log2(RX_DEPTH)+1.
- When IP_ENABLE is low, sr holds and updates are ignored.

## Timing
- Reset values:
  - sr = 0, err = 0, RX FIFO empty.
  - rx_valid = 0, rx_data = 0, tx_ready = 0, ER2_TDO = 0.
- Reset asserted mid-shift or mid-update aborts the operation; no partial push occurs.
- Capture, shift and update all act on the rising JTCK edge where the qualifier is sampled high.
- Push via update: rx_valid/rx_data are visible the cycle after the update edge (1-cycle latency).
- tx_ready is high for exactly the cycle after the update edge.
- rx_data is registered from the FIFO head and changes the cycle after a pop.
- ER2_TDO is combinational from sr[0], with no extra stage.

## Configuration
- ER2_MBOX_PARITY_EN defined:
  - sr is 12 bits.
  - Capture loads sr[11] = ~^sr_capture[10:0], giving odd parity over 12 bits.
  - An update executes only if ^sr[11:0] == 1. Otherwise the op is discarded and err is set.
- Not defined: sr is 11 bits and all updates execute.

## Test plan
- Reset then capture with tx_valid = 0 and FIFO empty -> shifted-out word 0x000; rx_valid = 0.
- Shift in op=01, data=0xA5, then update -> next cycle rx_valid = 1, rx_data = 0xA5. Assert rx_ready for one cycle -> rx_valid = 0.
- tx_valid = 1, tx_data = 0x3C, capture and shift -> out bits [8:0] = 0x13C. Then op=10 update -> tx_ready pulses exactly 1 cycle.
- Push 5 bytes 0x01..0x05 with RX_DEPTH = 4 and rx_ready = 0 -> FIFO holds 0x01..0x04 and 0x05 is dropped. Next capture bits[10:9] = 2'b11. Then op=11 -> rx_valid = 0 and next capture bit10 = 0.
- Push while full with rx_ready = 1 in the update cycle -> 0x01 popped, new byte accepted, count stays 4, err stays 0.
- JRSTN pulled low between shift bits 5 and 6 of a push -> no byte pushed and all outputs at reset values. With ER2_MBOX_PARITY_EN, a word with bad parity -> no push and err = 1.

Source files
------------

// File: rtl/er2_jtag_mailbox.sv
// er2_jtag_mailbox
// ----------------
// One ER2 data-register slot of the ER1/ER2 JTAG structure. It implements a
// byte mailbox between the JTAG host and an IP core. Everything runs in the
// JTCK domain.
//
// Build option:
//   ER2_MBOX_PARITY_EN -- widens the shift register to 12 bits. Capture loads
//                         an odd-parity bit into sr[11]. Any update whose
//                         12-bit word does not have odd parity is discarded
//                         and sets err.
//
// Ports:
//   JTCK       JTAG clock (the only clock)
//   JRSTN      asynchronous active-low reset
//   JTDI       serial data in
//   JSHIFT     high in Shift-DR
//   JUPDATE    one-cycle pulse in Update-DR
//   JCE2       ER2 instruction active (Capture-DR/Shift-DR)
//   IP_ENABLE  this slot's select bit from the ER1 decoder
//   ER2_TDO    serial data out (sr[0])
//   rx_data    registered head byte of the RX FIFO, 0 when empty
//   rx_valid   RX FIFO not empty
//   rx_ready   IP accepts rx_data
//   tx_data    byte offered to the host
//   tx_valid   tx_data valid, held until tx_ready
//   tx_ready   one-cycle pulse: host consumed tx_data
//
// Shift word layout: [10:9] op, [8] tx_valid (capture only), [7:0] data.
// On capture, [9] carries RX-full and [10] carries the sticky error flag.

module er2_jtag_mailbox #(
    parameter int unsigned RX_DEPTH = 4
) (
    input  logic       JTCK,
    input  logic       JRSTN,
    input  logic       JTDI,
    input  logic       JSHIFT,
    input  logic       JUPDATE,
    input  logic       JCE2,
    input  logic       IP_ENABLE,
    output logic       ER2_TDO,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready
);

`ifdef ER2_MBOX_PARITY_EN
    localparam int unsigned SR_W = 12;
`else
    localparam int unsigned SR_W = 11;
`endif
    localparam int unsigned AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(RX_DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

    logic [SR_W-1:0] sr;
    logic            err;
    logic [7:0]      mem [RX_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;

    logic            sel, upd, parity_ok, upd_exec, par_err;
    logic [1:0]      op;
    logic            do_push, do_tx, do_flush;
    logic            pop, full, push_acc, drop;
    logic [10:0]     cap_word;
    logic [AW-1:0]   wr_next, rd_next;
    logic [AW:0]     cnt_next;
    logic [7:0]      head_next;

    assign sel      = JCE2 & IP_ENABLE;
    assign upd      = JUPDATE & IP_ENABLE;
    assign full     = (count == FULL_CNT);
    assign rx_valid = (count != '0);
    assign ER2_TDO  = sr[0];
    assign op       = sr[10:9];
    assign pop      = rx_valid & rx_ready;

    assign cap_word = {err, full, tx_valid, (tx_valid ? tx_data : 8'h00)};

`ifdef ER2_MBOX_PARITY_EN
    assign parity_ok = ^sr;
`else
    assign parity_ok = 1'b1;
`endif
    assign upd_exec = upd & parity_ok;
    assign par_err  = upd & ~parity_ok;

    assign do_push  = upd_exec & (op == 2'b01);
    assign do_tx    = upd_exec & (op == 2'b10);
    assign do_flush = upd_exec & (op == 2'b11);

    // A pop in the same cycle frees the slot the push needs.
    assign push_acc = do_push & (~full | pop);
    assign drop     = do_push & full & ~pop;

    // Next FIFO state is computed up front so rx_data can be registered
    // directly from the post-update head.
    always_comb begin
        wr_next   = wr_ptr;
        rd_next   = rd_ptr;
        cnt_next  = count;
        head_next = 8'h00;
        if (do_flush) begin
            wr_next  = '0;
            rd_next  = '0;
            cnt_next = '0;
        end else begin
            if (push_acc) wr_next = wr_ptr + PTR_ONE;
            if (pop)      rd_next = rd_ptr + PTR_ONE;
            case ({push_acc, pop})
                2'b10:   cnt_next = count + CNT_ONE;
                2'b01:   cnt_next = count - CNT_ONE;
                default: cnt_next = count;
            endcase
        end
        if (cnt_next != '0) begin
            // A byte written this cycle into the new head slot is not yet in mem.
            if (push_acc && (wr_ptr == rd_next))
                head_next = sr[7:0];
            else
                head_next = mem[rd_next];
        end
    end

    // Shift register: capture / shift, held when the slot is not selected.
    always_ff @(posedge JTCK or negedge JRSTN) begin
        if (!JRSTN) begin
            sr <= '0;
        end else if (sel) begin
            if (JSHIFT)
                sr <= {JTDI, sr[SR_W-1:1]};
            else
`ifdef ER2_MBOX_PARITY_EN
                sr <= {~^cap_word, cap_word};
`else
                sr <= cap_word;
`endif
        end
    end

    // FIFO storage needs no reset: reads are gated by count.
    always_ff @(posedge JTCK) begin
        if (push_acc)
            mem[wr_ptr] <= sr[7:0];
    end

    always_ff @(posedge JTCK or negedge JRSTN) begin
        if (!JRSTN) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rx_data  <= 8'h00;
            err      <= 1'b0;
            tx_ready <= 1'b0;
        end else begin
            wr_ptr   <= wr_next;
            rd_ptr   <= rd_next;
            count    <= cnt_next;
            rx_data  <= head_next;
            tx_ready <= do_tx & tx_valid;
            if (do_flush)
                err <= 1'b0;
            else if (drop || par_err)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_er2_jtag_mailbox.sv
// Directed testbench for er2_jtag_mailbox (RX_DEPTH = 4).
// Inputs are driven and outputs sampled on the falling JTCK edge.

module tb_er2_jtag_mailbox;

`ifdef ER2_MBOX_PARITY_EN
    localparam int unsigned SR_W = 12;
`else
    localparam int unsigned SR_W = 11;
`endif

    logic       JTCK, JRSTN, JTDI, JSHIFT, JUPDATE, JCE2, IP_ENABLE;
    logic       ER2_TDO;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;

    int checks = 0;
    int errors = 0;

    er2_jtag_mailbox #(.RX_DEPTH(4)) dut (
        .JTCK(JTCK), .JRSTN(JRSTN), .JTDI(JTDI), .JSHIFT(JSHIFT),
        .JUPDATE(JUPDATE), .JCE2(JCE2), .IP_ENABLE(IP_ENABLE),
        .ER2_TDO(ER2_TDO), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready)
    );

    initial begin
        JTCK = 1'b0;
        forever #5 JTCK = ~JTCK;
    end

    // Full expected shift word for an 11-bit payload (adds odd parity bit).
    function automatic logic [SR_W-1:0] exp_cap(input logic [10:0] p);
`ifdef ER2_MBOX_PARITY_EN
        return {~^p, p};
`else
        return p;
`endif
    endfunction

    // One DR scan: capture, shift SR_W bits, update. Returns the captured word.
    // bad_par flips the top (parity) bit; only used in parity builds.
    task automatic scan(input logic [1:0] op, input logic [7:0] data,
                        input logic ip_en, input logic pop_upd,
                        input logic bad_par, output logic [SR_W-1:0] cap);
        logic [SR_W-1:0] w;
        w = exp_cap({op, 1'b0, data});
        if (bad_par) w[SR_W-1] = ~w[SR_W-1];
        JCE2 = 1'b1; IP_ENABLE = ip_en; JSHIFT = 1'b0;
        @(posedge JTCK); @(negedge JTCK);
        JSHIFT = 1'b1;
        for (int i = 0; i < int'(SR_W); i++) begin
            JTDI = w[i];
            cap[i] = ER2_TDO;
            @(posedge JTCK); @(negedge JTCK);
        end
        JSHIFT = 1'b0; JCE2 = 1'b0; JUPDATE = 1'b1; rx_ready = pop_upd;
        @(posedge JTCK); @(negedge JTCK);
        JUPDATE = 1'b0; rx_ready = 1'b0; IP_ENABLE = 1'b1; JTDI = 1'b0;
    endtask

    task automatic pop_one();
        rx_ready = 1'b1;
        @(posedge JTCK); @(negedge JTCK);
        rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        JRSTN = 1'b0; JTDI = 1'b0; JSHIFT = 1'b0; JUPDATE = 1'b0; JCE2 = 1'b0;
        IP_ENABLE = 1'b1; rx_ready = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
        repeat (2) @(negedge JTCK);
        JRSTN = 1'b1;
        @(negedge JTCK);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b exp 0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h exp 00", rx_data); end
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL reset_tx_ready got %b exp 0", tx_ready); end
        checks++; if (ER2_TDO !== 1'b0) begin errors++; $display("FAIL reset_tdo got %b exp 0", ER2_TDO); end
    endtask

    task automatic test_capture_empty();
        logic [SR_W-1:0] cap;
        scan(2'b00, 8'h00, 1'b1, 1'b0, 1'b0, cap);
        checks++; if (cap !== exp_cap(11'h000)) begin errors++; $display("FAIL capture_empty got %h exp %h", cap, exp_cap(11'h000)); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL capture_empty_rx_valid got %b exp 0", rx_valid); end
    endtask

    task automatic test_push_pop();
        logic [SR_W-1:0] cap;
        scan(2'b01, 8'hA5, 1'b1, 1'b0, 1'b0, cap);
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL push_rx_valid got %b exp 1", rx_valid); end
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL push_rx_data got %h exp a5", rx_data); end
        pop_one();
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL pop_rx_valid got %b exp 0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL pop_rx_data got %h exp 00", rx_data); end
    endtask

    task automatic test_tx();
        logic [SR_W-1:0] cap;
        tx_data = 8'h3C; tx_valid = 1'b1;
        scan(2'b10, 8'h00, 1'b1, 1'b0, 1'b0, cap);
        checks++; if (cap[8:0] !== 9'h13C) begin errors++; $display("FAIL tx_capture_low got %h exp 13c", cap[8:0]); end
        checks++; if (cap !== exp_cap(11'h13C)) begin errors++; $display("FAIL tx_capture_word got %h exp %h", cap, exp_cap(11'h13C)); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL tx_ready_pulse got %b exp 1", tx_ready); end
        @(negedge JTCK);
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL tx_ready_width got %b exp 0", tx_ready); end
        tx_valid = 1'b0; tx_data = 8'h00;
        scan(2'b10, 8'h00, 1'b1, 1'b0, 1'b0, cap);
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL tx_ready_no_valid got %b exp 0", tx_ready); end
    endtask

    task automatic test_overflow();
        logic [SR_W-1:0] cap;
        for (int i = 1; i <= 5; i++) scan(2'b01, 8'(i), 1'b1, 1'b0, 1'b0, cap);
        checks++; if (rx_data !== 8'h01) begin errors++; $display("FAIL overflow_head got %h exp 01", rx_data); end
        scan(2'b00, 8'h00, 1'b1, 1'b0, 1'b0, cap);
        checks++; if (cap !== exp_cap(11'h600)) begin errors++; $display("FAIL overflow_status got %h exp %h", cap, exp_cap(11'h600)); end
        scan(2'b11, 8'h00, 1'b1, 1'b0, 1'b0, cap);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL flush_rx_valid got %b exp 0", rx_valid); end
        scan(2'b00, 8'h00, 1'b1, 1'b0, 1'b0, cap);
        checks++; if (cap !== exp_cap(11'h000)) begin errors++; $display("FAIL flush_status got %h exp %h", cap, exp_cap(11'h000)); end
    endtask

    task automatic test_push_while_full();
        logic [SR_W-1:0] cap;
        logic [7:0] exp_q [4];
        exp_q = '{8'h02, 8'h03, 8'h04, 8'h06};
        for (int i = 1; i <= 4; i++) scan(2'b01, 8'(i), 1'b1, 1'b0, 1'b0, cap);
        scan(2'b01, 8'h06, 1'b1, 1'b1, 1'b0, cap);
        checks++; if (rx_data !== 8'h02) begin errors++; $display("FAIL full_pop_head got %h exp 02", rx_data); end
        scan(2'b00, 8'h00, 1'b1, 1'b0, 1'b0, cap);
        checks++; if (cap !== exp_cap(11'h200)) begin errors++; $display("FAIL full_pop_status got %h exp %h", cap, exp_cap(11'h200)); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rx_data !== exp_q[i]) begin errors++; $display("FAIL drain_%0d got %h exp %h", i, rx_data, exp_q[i]); end
            pop_one();
        end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b exp 0", rx_valid); end
    endtask

    task automatic test_reset_mid_shift();
        logic [SR_W-1:0] cap;
        logic [SR_W-1:0] w;
        scan(2'b01, 8'h11, 1'b1, 1'b0, 1'b0, cap);
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_rx_valid got %b exp 1", rx_valid); end
        w = exp_cap({2'b01, 1'b0, 8'h77});
        JCE2 = 1'b1; IP_ENABLE = 1'b1; JSHIFT = 1'b0;
        @(posedge JTCK); @(negedge JTCK);
        JSHIFT = 1'b1;
        for (int i = 0; i < 6; i++) begin
            JTDI = w[i];
            @(posedge JTCK); @(negedge JTCK);
        end
        JRSTN = 1'b0;
        #1;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid got %b exp 0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_rx_data got %h exp 00", rx_data); end
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL rst_tx_ready got %b exp 0", tx_ready); end
        checks++; if (ER2_TDO !== 1'b0) begin errors++; $display("FAIL rst_tdo got %b exp 0", ER2_TDO); end
        JSHIFT = 1'b0; JCE2 = 1'b0; JTDI = 1'b0;
        @(posedge JTCK); @(negedge JTCK);
        JRSTN = 1'b1; JUPDATE = 1'b1;
        @(posedge JTCK); @(negedge JTCK);
        JUPDATE = 1'b0;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_no_push got %b exp 0", rx_valid); end
        scan(2'b00, 8'h00, 1'b1, 1'b0, 1'b0, cap);
        checks++; if (cap !== exp_cap(11'h000)) begin errors++; $display("FAIL rst_status got %h exp %h", cap, exp_cap(11'h000)); end
    endtask

    task automatic test_ip_disabled();
        logic [SR_W-1:0] cap;
        scan(2'b01, 8'h42, 1'b0, 1'b0, 1'b0, cap);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL disabled_push got %b exp 0", rx_valid); end
        scan(2'b00, 8'h00, 1'b1, 1'b0, 1'b0, cap);
        checks++; if (cap !== exp_cap(11'h000)) begin errors++; $display("FAIL disabled_status got %h exp %h", cap, exp_cap(11'h000)); end
    endtask

`ifdef ER2_MBOX_PARITY_EN
    task automatic test_parity();
        logic [SR_W-1:0] cap;
        scan(2'b01, 8'h55, 1'b1, 1'b0, 1'b1, cap);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL parity_no_push got %b exp 0", rx_valid); end
        scan(2'b00, 8'h00, 1'b1, 1'b0, 1'b0, cap);
        checks++; if (cap !== exp_cap(11'h400)) begin errors++; $display("FAIL parity_err got %h exp %h", cap, exp_cap(11'h400)); end
    endtask
`endif

    initial begin
        test_reset();
        test_capture_empty();
        test_push_pop();
        test_tx();
        test_overflow();
        test_push_while_full();
        test_reset_mid_shift();
        test_ip_disabled();
`ifdef ER2_MBOX_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
